// File: rtl/collision_scan.sv
// Sequential terrain collision scanner: walks a writable rectangle table one entry per clock
// for PLAYERS sprites in parallel. Optional COLLISION_INDEX_EN adds hit_any/hit_idx outputs.
module collision_scan #(
   parameter int SIZE     = 16,
   parameter int RECT_NUM = 11,
   parameter int PLAYERS  = 2,
   parameter int COORD_W  = 10,
   localparam int IDX_W   = (RECT_NUM > 1) ? $clog2(RECT_NUM) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   input  logic [PLAYERS*COORD_W-1:0] xpos,
   input  logic [PLAYERS*COORD_W-1:0] ypos,
   input  logic                       tbl_we,
   input  logic [IDX_W-1:0]           tbl_addr,
   input  logic                       tbl_en,
   input  logic [COORD_W-1:0]         tbl_x1,
   input  logic [COORD_W-1:0]         tbl_y1,
   input  logic [COORD_W-1:0]         tbl_x2,
   input  logic [COORD_W-1:0]         tbl_y2,
   output logic [PLAYERS-1:0]         collision_up,
   output logic [PLAYERS-1:0]         collision_down,
   output logic [PLAYERS-1:0]         collision_right,
   output logic [PLAYERS-1:0]         collision_left
`ifdef COLLISION_INDEX_EN
   ,
   output logic [PLAYERS-1:0]         hit_any,
   output logic [PLAYERS*IDX_W-1:0]   hit_idx
`endif
);

   localparam int CW = COORD_W + 1;
   localparam logic [CW-1:0] S_EXT = CW'(SIZE);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [PLAYERS*COORD_W-1:0] xs_q, xs_d, ys_q, ys_d;
   logic [RECT_NUM-1:0]        vld_q, vld_d;
   logic [PLAYERS-1:0]         acc_up_q, acc_up_d, acc_dn_q, acc_dn_d;
   logic [PLAYERS-1:0]         acc_rt_q, acc_rt_d, acc_lf_q, acc_lf_d;
   logic [PLAYERS-1:0]         up_q, up_d, dn_q, dn_d, rt_q, rt_d, lf_q, lf_d;
   logic                       done_q, done_d;
   logic [PLAYERS-1:0]         acc_any_q, acc_any_d, any_q, any_d;
   logic [PLAYERS*IDX_W-1:0]   acc_idx_q, acc_idx_d, hidx_q, hidx_d;

   logic [COORD_W-1:0] x1_q [RECT_NUM];
   logic [COORD_W-1:0] y1_q [RECT_NUM];
   logic [COORD_W-1:0] x2_q [RECT_NUM];
   logic [COORD_W-1:0] y2_q [RECT_NUM];

   logic               wr_ok;
   logic [PLAYERS-1:0] h_up, h_dn, h_rt, h_lf, h_any;

   assign wr_ok = (state_q == IDLE) && tbl_we && ({1'b0, tbl_addr} < (IDX_W+1)'(RECT_NUM));

   // NOTE: corner storage has no reset; only the valid bits gate its use, so stale corners are harmless.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         x1_q[tbl_addr] <= tbl_x1;
         y1_q[tbl_addr] <= tbl_y1;
         x2_q[tbl_addr] <= tbl_x2;
         y2_q[tbl_addr] <= tbl_y2;
      end
   end

   // Widened compares against the current entry; SIZE is only ever added, never subtracted.
   always_comb begin
      logic [CW-1:0] xp, yp, x1, y1, x2, y2;
      h_up  = '0;
      h_dn  = '0;
      h_rt  = '0;
      h_lf  = '0;
      h_any = '0;
      x1 = {1'b0, x1_q[idx_q]};
      y1 = {1'b0, y1_q[idx_q]};
      x2 = {1'b0, x2_q[idx_q]};
      y2 = {1'b0, y2_q[idx_q]};
      for (int p = 0; p < PLAYERS; p++) begin
         xp = {1'b0, xs_q[p*COORD_W +: COORD_W]};
         yp = {1'b0, ys_q[p*COORD_W +: COORD_W]};
         if (vld_q[idx_q]) begin
            h_up[p] = (xp + S_EXT > x1) && (xp < x2 + S_EXT) && (yp < y2 + S_EXT) && (yp > y1 + S_EXT);
            h_dn[p] = (xp + S_EXT > x1) && (xp < x2 + S_EXT) && (yp + S_EXT > y1) && (yp + S_EXT < y2);
            h_rt[p] = (xp + S_EXT > x1) && (xp + S_EXT < x2) && (yp + S_EXT > y1) && (yp < y2 + S_EXT);
            h_lf[p] = (xp < x2 + S_EXT) && (xp > x1 + S_EXT) && (yp + S_EXT > y1) && (yp < y2 + S_EXT);
         end
         h_any[p] = h_up[p] | h_dn[p] | h_rt[p] | h_lf[p];
      end
   end

   // NOTE: every *_d gets a default up front so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      xs_d      = xs_q;
      ys_d      = ys_q;
      vld_d     = vld_q;
      acc_up_d  = acc_up_q;
      acc_dn_d  = acc_dn_q;
      acc_rt_d  = acc_rt_q;
      acc_lf_d  = acc_lf_q;
      acc_any_d = acc_any_q;
      acc_idx_d = acc_idx_q;
      up_d      = up_q;
      dn_d      = dn_q;
      rt_d      = rt_q;
      lf_d      = lf_q;
      any_d     = any_q;
      hidx_d    = hidx_q;
      done_d    = 1'b0;
      if (wr_ok) vld_d[tbl_addr] = tbl_en;
      case (state_q)
         IDLE: if (start) begin
            state_d   = SCAN;
            idx_d     = '0;
            xs_d      = xpos;
            ys_d      = ypos;
            acc_up_d  = '0;
            acc_dn_d  = '0;
            acc_rt_d  = '0;
            acc_lf_d  = '0;
            acc_any_d = '0;
            acc_idx_d = '0;
         end
         SCAN: begin
            acc_up_d  = acc_up_q | h_up;
            acc_dn_d  = acc_dn_q | h_dn;
            acc_rt_d  = acc_rt_q | h_rt;
            acc_lf_d  = acc_lf_q | h_lf;
            acc_any_d = acc_any_q | h_any;
            for (int p = 0; p < PLAYERS; p++)
               if (h_any[p] && !acc_any_q[p]) acc_idx_d[p*IDX_W +: IDX_W] = idx_q;
            // Results are loaded on the edge into DONE so they are visible alongside the done strobe.
            if (idx_q == IDX_W'(RECT_NUM - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               up_d    = acc_up_d;
               dn_d    = acc_dn_d;
               rt_d    = acc_rt_d;
               lf_d    = acc_lf_d;
               any_d   = acc_any_d;
               hidx_d  = acc_idx_d;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         xs_q      <= '0;
         ys_q      <= '0;
         vld_q     <= '0;
         acc_up_q  <= '0;
         acc_dn_q  <= '0;
         acc_rt_q  <= '0;
         acc_lf_q  <= '0;
         acc_any_q <= '0;
         acc_idx_q <= '0;
         up_q      <= '0;
         dn_q      <= '0;
         rt_q      <= '0;
         lf_q      <= '0;
         any_q     <= '0;
         hidx_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         xs_q      <= xs_d;
         ys_q      <= ys_d;
         vld_q     <= vld_d;
         acc_up_q  <= acc_up_d;
         acc_dn_q  <= acc_dn_d;
         acc_rt_q  <= acc_rt_d;
         acc_lf_q  <= acc_lf_d;
         acc_any_q <= acc_any_d;
         acc_idx_q <= acc_idx_d;
         up_q      <= up_d;
         dn_q      <= dn_d;
         rt_q      <= rt_d;
         lf_q      <= lf_d;
         any_q     <= any_d;
         hidx_q    <= hidx_d;
         done_q    <= done_d;
      end
   end

   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign collision_up    = up_q;
   assign collision_down  = dn_q;
   assign collision_right = rt_q;
   assign collision_left  = lf_q;
`ifdef COLLISION_INDEX_EN
   assign hit_any = any_q;
   assign hit_idx = hidx_q;
`endif

endmodule

// File: tb/tb_collision_scan.sv
// Scoreboard bench for collision_scan: directed scans push expected flags, a done-driven
// monitor pops and compares. Checks hit_any/hit_idx too when COLLISION_INDEX_EN is defined.
module tb_collision_scan;

   localparam int P  = 2;
   localparam int CW = 10;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            rst, start, busy, done;
   logic [P*CW-1:0] xpos, ypos;
   logic            tbl_we, tbl_en;
   logic [IW-1:0]   tbl_addr;
   logic [CW-1:0]   tbl_x1, tbl_y1, tbl_x2, tbl_y2;
   logic [P-1:0]    c_up, c_dn, c_rt, c_lf;
`ifdef COLLISION_INDEX_EN
   logic [P-1:0]    hit_any;
   logic [P*IW-1:0] hit_idx;
`endif

   typedef struct {
      logic [1:0] up, dn, rt, lf, any;
      logic [7:0] idx;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   collision_scan dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .xpos(xpos), .ypos(ypos), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_en(tbl_en),
      .tbl_x1(tbl_x1), .tbl_y1(tbl_y1), .tbl_x2(tbl_x2), .tbl_y2(tbl_y2),
      .collision_up(c_up), .collision_down(c_dn), .collision_right(c_rt), .collision_left(c_lf)
`ifdef COLLISION_INDEX_EN
      , .hit_any(hit_any), .hit_idx(hit_idx)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] up, dn, rt, lf, any, input logic [7:0] idx);
      exp_t e;
      e.up = up; e.dn = dn; e.rt = rt; e.lf = lf; e.any = any; e.idx = idx;
      return e;
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_done", {31'b0, done}, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("up",    {30'b0, c_up}, {30'b0, e.up});
            check("down",  {30'b0, c_dn}, {30'b0, e.dn});
            check("right", {30'b0, c_rt}, {30'b0, e.rt});
            check("left",  {30'b0, c_lf}, {30'b0, e.lf});
`ifdef COLLISION_INDEX_EN
            check("hit_any", {30'b0, hit_any}, {30'b0, e.any});
            check("hit_idx", {24'b0, hit_idx}, {24'b0, e.idx});
`endif
         end
      end
   end

   task automatic setpos(input int x0, y0, x1, y1);
      xpos = {CW'(x1), CW'(x0)};
      ypos = {CW'(y1), CW'(y0)};
   endtask

   task automatic wr(input int a, input logic en, input int x1, y1, x2, y2);
      tbl_we = 1'b1; tbl_addr = IW'(a); tbl_en = en;
      tbl_x1 = CW'(x1); tbl_y1 = CW'(y1); tbl_x2 = CW'(x2); tbl_y2 = CW'(y2);
      @(posedge clk); #1;
      tbl_we = 1'b0;
   endtask

   // mode 0: plain scan, 1: write/start/xpos disturbance mid-scan, 2: reset at scan cycle 5
   task automatic run_scan(input exp_t e, input int mode);
      int lat;
      lat = 0;
      if (mode != 2) q.push_back(e);
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      tbl_we = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) check("busy_cycle1", {31'b0, busy}, 32'd1);
         if (mode == 1 && k == 3) begin
            tbl_we = 1'b1; tbl_addr = '0; tbl_en = 1'b0;
            start  = 1'b1;
            setpos(900, 900, 900, 900);
         end
         if (mode == 1 && k == 4) begin
            tbl_we = 1'b0;
            start  = 1'b0;
         end
         if (mode == 2 && k == 5) rst = 1'b1;
         if (mode == 2 && k == 6) begin
            check("rst_busy",  {31'b0, busy}, 32'd0);
            check("rst_done",  {31'b0, done}, 32'd0);
            check("rst_flags", {24'b0, c_up, c_dn, c_rt, c_lf}, 32'd0);
            rst = 1'b0;
         end
         if (done === 1'b1) begin
            lat = k;
            check("busy_at_done", {31'b0, busy}, 32'd1);
            break;
         end
      end
      if (mode != 2) check("done_latency", lat, 12);
      @(posedge clk); #1;
      if (mode != 2) check("busy_after", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; tbl_we = 1'b0; tbl_en = 1'b0; tbl_addr = '0;
      tbl_x1 = '0; tbl_y1 = '0; tbl_x2 = '0; tbl_y2 = '0;
      setpos(100, 100, 400, 400);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_busy",  {31'b0, busy}, 32'd0);
      check("reset_done",  {31'b0, done}, 32'd0);
      check("reset_flags", {24'b0, c_up, c_dn, c_rt, c_lf}, 32'd0);
      @(posedge clk); #1;

      // empty table
      run_scan(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00), 0);
      // entry 0 hit for player 0 only
      wr(0, 1'b1, 50, 110, 200, 300);
      run_scan(mk(2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 8'h00), 0);
      // entry 3 near origin for player 0, entry 0 for player 1; disturbances mid-scan
      wr(3, 1'b1, 0, 0, 40, 40);
      setpos(5, 5, 100, 100);
      run_scan(mk(2'b00, 2'b11, 2'b11, 2'b10, 2'b11, 8'h03), 1);
      // dropped write: entry 0 still valid
      setpos(100, 100, 400, 400);
      run_scan(mk(2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 8'h00), 0);
      // write and start in the same cycle: scan sees entry 5
      setpos(100, 100, 640, 590);
      tbl_we = 1'b1; tbl_addr = 4'd5; tbl_en = 1'b1;
      tbl_x1 = 10'd600; tbl_y1 = 10'd600; tbl_x2 = 10'd700; tbl_y2 = 10'd700;
      run_scan(mk(2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 8'h50), 0);
      // strict-inequality edge: x+S == x1 misses, x+S == x1+1 hits
      setpos(34, 100, 35, 100);
      run_scan(mk(2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 8'h00), 0);
      // reset mid-scan, then reload and rescan
      setpos(100, 100, 400, 400);
      run_scan(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00), 2);
      wr(0, 1'b1, 50, 110, 200, 300);
      run_scan(mk(2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 8'h00), 0);
      // hits on entries 2 and 7 only: lowest index is 2
      wr(0, 1'b0, 50, 110, 200, 300);
      wr(2, 1'b1, 50, 110, 200, 300);
      wr(7, 1'b1, 50, 110, 200, 300);
      run_scan(mk(2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 8'h02), 0);

      repeat (3) @(posedge clk);
      check("queue_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
